// File: rtl/jacobian_to_affine_pkg.sv
// rtl/jacobian_to_affine_pkg.sv - shared ECC types: controller states and default operand width
package ecc_pkg;

  localparam int DEFAULT_WIDTH = 256;

  typedef enum logic [2:0] {
    IDLE,
    INV,
    MUL_Z2,
    MUL_Z3,
    MUL_X,
    MUL_Y,
    DONE
  } state_t;

endpackage

// File: rtl/jacobian_to_affine_if.sv
// rtl/jacobian_to_affine_if.sv - request/result bundle between a point-arithmetic client and the converter
interface jacobian_to_affine_if #(
  parameter int WIDTH = ecc_pkg::DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] x3;
  logic [WIDTH-1:0] y3;
  logic [WIDTH-1:0] z3;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic             err;

  modport master (output start, x3, y3, z3, p, input x, y, busy, done, err);
  modport slave  (input start, x3, y3, z3, p, output x, y, busy, done, err);
endinterface

// File: rtl/jacobian_to_affine_mod_mul_il.sv
// rtl/jacobian_to_affine_mod_mul_il.sv - MSB-first interleaved modular multiplier, one bit of a per cycle
module mod_mul_il #(
  parameter int WIDTH = ecc_pkg::DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] r,
  output logic             rdy
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH+1:0] acc;
  logic [WIDTH+1:0] p_ext;
  logic [WIDTH+1:0] t0;
  logic [WIDTH+1:0] t1;
  logic [WIDTH+1:0] t2;
  logic [CW-1:0]    cnt;
  logic             run;

  // acc < p, so 2*acc + b < 3p: two conditional subtractions restore acc < p
  always_comb begin
    p_ext = {2'b00, p_q};
    t0    = (acc << 1) + (a_sh[WIDTH-1] ? {2'b00, b_q} : '0);
    t1    = (t0 >= p_ext) ? (t0 - p_ext) : t0;
    t2    = (t1 >= p_ext) ? (t1 - p_ext) : t1;
  end

  assign r   = t2[WIDTH-1:0];
  assign rdy = run && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      run <= 1'b0;
      acc <= '0;
      cnt <= '0;
    end else if (go) begin
      run <= 1'b1;
      acc <= '0;
      cnt <= CW'(WIDTH - 1);
    end else if (run) begin
      acc <= t2;
      cnt <= cnt - 1'b1;
      if (cnt == '0) begin
        run <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (go) begin
      a_sh <= a;
      b_q  <= b;
      p_q  <= p;
    end else if (run) begin
      a_sh <= a_sh << 1;
    end
  end

endmodule

// File: rtl/jacobian_to_affine.sv
// rtl/jacobian_to_affine.sv - Jacobian to affine conversion; define JAC_AFFINE_X_EN to compute the x output
module jacobian_to_affine
  import ecc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                 clk,
  input logic                 rst,
  jacobian_to_affine_if.slave bus
);
  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] u;
  logic [WIDTH-1:0] v;
  logic [WIDTH-1:0] ia;
  logic [WIDTH-1:0] ib;
  logic [WIDTH-1:0] zinv;
  logic [WIDTH-1:0] z2;
  logic [WIDTH-1:0] z3;
  logic [WIDTH-1:0] y_res;
  logic             err_q;
  logic             is_mul;
  logic             mul_run;
  logic             mul_go;
  logic             mul_rdy;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH-1:0] mul_r;
`ifdef JAC_AFFINE_X_EN
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] x_res;
`else
  logic             unused_x3;
  assign unused_x3 = ^bus.x3;
`endif

  // (val / 2) mod m for odd m; val+m needs one extra bit
  function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] val,
                                                input logic [WIDTH-1:0] m);
    logic [WIDTH:0] s;
    s = val[0] ? ({1'b0, val} + {1'b0, m}) : {1'b0, val};
    return s[WIDTH:1];
  endfunction

  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] lhs,
                                               input logic [WIDTH-1:0] rhs,
                                               input logic [WIDTH-1:0] m);
    return (lhs >= rhs) ? (lhs - rhs) : (lhs - rhs + m);
  endfunction

  always_comb begin
    state_nxt = state;
    is_mul    = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    case (state)
      IDLE: if (bus.start) state_nxt = INV;
      INV: begin
        if (u == '0) state_nxt = DONE;
        else if (u == WIDTH'(1) || v == WIDTH'(1)) state_nxt = MUL_Z2;
      end
      MUL_Z2: begin
        is_mul = 1'b1;
        mul_a  = zinv;
        mul_b  = zinv;
        if (mul_rdy) state_nxt = MUL_Z3;
      end
      MUL_Z3: begin
        is_mul = 1'b1;
        mul_a  = z2;
        mul_b  = zinv;
`ifdef JAC_AFFINE_X_EN
        if (mul_rdy) state_nxt = MUL_X;
`else
        if (mul_rdy) state_nxt = MUL_Y;
`endif
      end
`ifdef JAC_AFFINE_X_EN
      MUL_X: begin
        is_mul = 1'b1;
        mul_a  = x_q;
        mul_b  = z2;
        if (mul_rdy) state_nxt = MUL_Y;
      end
`endif
      MUL_Y: begin
        is_mul = 1'b1;
        mul_a  = y_q;
        mul_b  = z3;
        if (mul_rdy) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // the multiplier is loaded on the first cycle of every multiply state
  assign mul_go = is_mul && !mul_run;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_run <= 1'b0;
      err_q   <= 1'b0;
      y_res   <= '0;
`ifdef JAC_AFFINE_X_EN
      x_res   <= '0;
`endif
    end else begin
      if (mul_rdy)     mul_run <= 1'b0;
      else if (mul_go) mul_run <= 1'b1;
      if (state == INV && u == '0) begin
        err_q <= 1'b1;
        y_res <= '0;
`ifdef JAC_AFFINE_X_EN
        x_res <= '0;
`endif
      end else if (state == MUL_Y && mul_rdy) begin
        err_q <= 1'b0;
        y_res <= mul_r;
`ifdef JAC_AFFINE_X_EN
        x_res <= z2;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (bus.start) begin
          p_q <= bus.p;
          y_q <= bus.y3;
          u   <= bus.z3;
          v   <= bus.p;
          ia  <= WIDTH'(1);
          ib  <= '0;
`ifdef JAC_AFFINE_X_EN
          x_q <= bus.x3;
`endif
        end
      end
      INV: begin
        if (u == '0) begin
        end else if (u == WIDTH'(1)) begin
          zinv <= ia;
        end else if (v == WIDTH'(1)) begin
          zinv <= ib;
        end else if (!u[0]) begin
          u  <= u >> 1;
          ia <= half_mod(ia, p_q);
        end else if (!v[0]) begin
          v  <= v >> 1;
          ib <= half_mod(ib, p_q);
        end else if (u >= v) begin
          u  <= u - v;
          ia <= sub_mod(ia, ib, p_q);
        end else begin
          v  <= v - u;
          ib <= sub_mod(ib, ia, p_q);
        end
      end
      MUL_Z2: if (mul_rdy) z2 <= mul_r;
      MUL_Z3: if (mul_rdy) z3 <= mul_r;
      // Z^-2 is dead once MUL_X starts, so its register carries X*Z^-2 onward
      MUL_X:  if (mul_rdy) z2 <= mul_r;
      default: ;
    endcase
  end

  mod_mul_il #(.WIDTH(WIDTH)) u_mul (
    .clk (clk),
    .rst (rst),
    .go  (mul_go),
    .a   (mul_a),
    .b   (mul_b),
    .p   (p_q),
    .r   (mul_r),
    .rdy (mul_rdy)
  );

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.err  = err_q;
  assign bus.y    = y_res;
`ifdef JAC_AFFINE_X_EN
  assign bus.x    = x_res;
`else
  assign bus.x    = '0;
`endif

endmodule

// File: tb/tb_jacobian_to_affine.sv
// tb/tb_jacobian_to_affine.sv - bench for jacobian_to_affine at WIDTH 8 and 256; honours JAC_AFFINE_X_EN
module tb_jacobian_to_affine;
  localparam int WS = 8;
  localparam int WB = 256;
`ifdef JAC_AFFINE_X_EN
  localparam int M   = 4;
  localparam bit XEN = 1'b1;
`else
  localparam int M   = 3;
  localparam bit XEN = 1'b0;
`endif
  localparam logic [255:0] SECP_P  = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
  localparam logic [255:0] SECP_GX = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
  localparam logic [255:0] SECP_GY = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jacobian_to_affine_if #(.WIDTH(WS)) bs ();
  jacobian_to_affine_if #(.WIDTH(WB)) bb ();

  jacobian_to_affine #(.WIDTH(WS)) dut_s (.clk(clk), .rst(rst), .bus(bs.slave));
  jacobian_to_affine #(.WIDTH(WB)) dut_b (.clk(clk), .rst(rst), .bus(bb.slave));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [255:0] x3, y3, z3, p;
    logic [255:0] ex, ey;
    logic         eerr;
    int           k;
  } vec_t;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [255:0] mulmod(input logic [255:0] a, input logic [255:0] b,
                                          input logic [255:0] m);
    logic [511:0] t;
    t = {256'b0, a} * {256'b0, b};
    t = t % {256'b0, m};
    return t[255:0];
  endfunction

  function automatic logic [255:0] powmod(input logic [255:0] base, input logic [255:0] e,
                                          input logic [255:0] m);
    logic [255:0] acc;
    acc = 256'd1;
    for (int i = 255; i >= 0; i--) begin
      acc = mulmod(acc, acc, m);
      if (e[i]) acc = mulmod(acc, base, m);
    end
    return acc;
  endfunction

  // affine conversion from first principles: Z^-1 = Z^(p-2) by Fermat
  task automatic model(input logic [255:0] x3, y3, z3, p,
                       output logic [255:0] ex, ey, output logic eerr);
    logic [255:0] zi, zz2, zz3;
    if (z3 == '0) begin
      ex = '0; ey = '0; eerr = 1'b1;
    end else begin
      zi  = powmod(z3, p - 256'd2, p);
      zz2 = mulmod(zi, zi, p);
      zz3 = mulmod(zz2, zi, p);
      ex  = XEN ? mulmod(x3, zz2, p) : '0;
      ey  = mulmod(y3, zz3, p);
      eerr = 1'b0;
    end
  endtask

  function automatic logic [255:0] rand_below(input logic [255:0] m);
    logic [511:0] t;
    t = '0;
    for (int i = 0; i < 16; i++) t = {t[479:0], 32'($urandom)};
    t = t % {256'b0, m};
    return t[255:0];
  endfunction

  task automatic drive(input bit big, input logic st, input logic [255:0] x3, y3, z3, p);
    if (big) begin
      bb.start = st; bb.x3 = x3; bb.y3 = y3; bb.z3 = z3; bb.p = p;
    end else begin
      bs.start = st; bs.x3 = x3[7:0]; bs.y3 = y3[7:0]; bs.z3 = z3[7:0]; bs.p = p[7:0];
    end
  endtask

  function automatic logic o_done(input bit big); return big ? bb.done : bs.done; endfunction
  function automatic logic o_busy(input bit big); return big ? bb.busy : bs.busy; endfunction
  function automatic logic o_err(input bit big);  return big ? bb.err  : bs.err;  endfunction
  function automatic logic [255:0] o_x(input bit big); return big ? bb.x : {248'b0, bs.x}; endfunction
  function automatic logic [255:0] o_y(input bit big); return big ? bb.y : {248'b0, bs.y}; endfunction

  // lat is the cycle index of done, counting the start cycle as 0
  task automatic run_op(input bit big, input logic [255:0] x3, y3, z3, p, input int extra_at,
                        input int post, output logic [255:0] rx, ry, output logic rerr,
                        output int lat, output int ndone);
    int w, budget;
    w = big ? WB : WS;
    budget = 4 * w + M * (w + 1) + 20;
    @(negedge clk);
    drive(big, 1'b1, x3, y3, z3, p);
    @(negedge clk);
    lat = 1;
    drive(big, 1'b0, x3, y3, z3, p);
    check("busy_cycle1", o_busy(big), 1);
    while (o_done(big) !== 1'b1 && lat < budget) begin
      if (lat == extra_at) drive(big, 1'b1, x3 ^ 256'h3, y3 ^ 256'h1, 256'h1, p);
      else                 drive(big, 1'b0, x3, y3, z3, p);
      @(negedge clk);
      lat++;
    end
    drive(big, 1'b0, x3, y3, z3, p);
    check("done_within_budget", o_done(big), 1);
    rx = o_x(big);
    ry = o_y(big);
    rerr = o_err(big);
    ndone = 1;
    @(negedge clk);
    check("busy_drop_after_done", o_busy(big), 0);
    repeat (post) begin
      @(negedge clk);
      if (o_done(big)) ndone++;
    end
  endtask

  task automatic run_and_check(input string tag, input bit big, input logic [255:0] x3, y3, z3, p);
    logic [255:0] ex, ey, rx, ry;
    logic eerr, rerr;
    int lat, nd, k, w;
    w = big ? WB : WS;
    model(x3, y3, z3, p, ex, ey, eerr);
    run_op(big, x3, y3, z3, p, -1, 0, rx, ry, rerr, lat, nd);
    check({tag, "_x"}, rx, ex);
    check({tag, "_y"}, ry, ey);
    check({tag, "_err"}, rerr, eerr);
    if (eerr) begin
      check({tag, "_lat_zero"}, lat, 2);
    end else begin
      k = lat - M * (w + 1) - 1;
      check({tag, "_inv_bound"}, (k >= 1 && k <= 4 * w), 1);
    end
  endtask

  initial begin
    vec_t tbl[4];
    logic [255:0] rx, ry, p8;
    logic rerr;
    int lat, nd;

    tbl[0] = '{x3: 4, y3: 5, z3: 2, p: 23, ex: 1, ey: 15, eerr: 0, k: 2};
    tbl[1] = '{x3: 7, y3: 9, z3: 1, p: 23, ex: 7, ey: 9,  eerr: 0, k: 1};
    tbl[2] = '{x3: 3, y3: 8, z3: 0, p: 23, ex: 0, ey: 0,  eerr: 1, k: 1};
    tbl[3] = '{x3: 10, y3: 20, z3: 5, p: 23, ex: 5, ey: 2, eerr: 0, k: 6};

    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0, 256'd23);
    drive(1'b1, 1'b0, '0, '0, '0, SECP_P);
    repeat (3) @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      check("reset_x", o_x(b[0]), 0);
      check("reset_y", o_y(b[0]), 0);
      check("reset_busy", o_busy(b[0]), 0);
      check("reset_done", o_done(b[0]), 0);
      check("reset_err", o_err(b[0]), 0);
    end
    rst = 1'b0;

    foreach (tbl[i]) begin
      run_op(1'b0, tbl[i].x3, tbl[i].y3, tbl[i].z3, tbl[i].p, -1, 0, rx, ry, rerr, lat, nd);
      check($sformatf("vec%0d_x", i), rx, XEN ? tbl[i].ex : 256'd0);
      check($sformatf("vec%0d_y", i), ry, tbl[i].ey);
      check($sformatf("vec%0d_err", i), rerr, tbl[i].eerr);
      check($sformatf("vec%0d_latency", i), lat,
            tbl[i].eerr ? 2 : tbl[i].k + M * (WS + 1) + 1);
    end

    for (int i = 0; i < 24; i++) begin
      case (i % 3)
        0:       p8 = 256'd23;
        1:       p8 = 256'd101;
        default: p8 = 256'd251;
      endcase
      run_and_check($sformatf("rand8_%0d", i), 1'b0, rand_below(p8), rand_below(p8),
                    (i % 6 == 0) ? 256'd0 : rand_below(p8), p8);
    end

    run_op(1'b1, SECP_GX, SECP_GY, 256'd1, SECP_P, -1, 0, rx, ry, rerr, lat, nd);
    check("gen_x", rx, XEN ? SECP_GX : 256'd0);
    check("gen_y", ry, SECP_GY);
    check("gen_err", rerr, 0);
    check("gen_latency", lat, 1 + M * (WB + 1) + 1);

    for (int i = 0; i < 5; i++) begin
      run_and_check($sformatf("rand256_%0d", i), 1'b1, rand_below(SECP_P), rand_below(SECP_P),
                    rand_below(SECP_P), SECP_P);
    end
    run_and_check("zero256", 1'b1, SECP_GX, SECP_GY, 256'd0, SECP_P);

    // a second start during INV must be dropped, not queued
    run_op(1'b0, 256'd10, 256'd20, 256'd5, 256'd23, 3, 60, rx, ry, rerr, lat, nd);
    check("ignore_done_count", nd, 1);
    check("ignore_x", rx, XEN ? 256'd5 : 256'd0);
    check("ignore_y", ry, 256'd2);
    check("ignore_latency", lat, 6 + M * (WS + 1) + 1);

    // reset in the middle of MUL_Z3 (cycles 12..20 for Z=2, p=23)
    @(negedge clk);
    drive(1'b0, 1'b1, 256'd4, 256'd5, 256'd2, 256'd23);
    @(negedge clk);
    drive(1'b0, 1'b0, 256'd4, 256'd5, 256'd2, 256'd23);
    repeat (13) @(negedge clk);
    check("pre_reset_busy", o_busy(1'b0), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_x", o_x(1'b0), 0);
    check("midrst_y", o_y(1'b0), 0);
    check("midrst_busy", o_busy(1'b0), 0);
    check("midrst_done", o_done(1'b0), 0);
    check("midrst_err", o_err(1'b0), 0);
    rst = 1'b0;
    run_op(1'b0, 256'd4, 256'd5, 256'd2, 256'd23, -1, 0, rx, ry, rerr, lat, nd);
    check("after_rst_x", rx, XEN ? 256'd1 : 256'd0);
    check("after_rst_y", ry, 256'd15);
    check("after_rst_latency", lat, 2 + M * (WS + 1) + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
